// File: rtl/password_checker.sv
// Button code checker: PW_LEN-symbol entry, failure count, timed lockout, 7-seg status.
// Define PWCHK_PROG_EN to add prog_req and a PROG state that rewrites the code.
module password_checker #(
    parameter int N_BTN = 4,
    parameter int PW_LEN = 4,
    parameter int BW = (N_BTN > 1) ? $clog2(N_BTN) : 1,
    parameter logic [PW_LEN*BW-1:0] PASSWORD = 8'hE8,
    parameter int TIMEOUT_CYC = 30,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_pulse,
    input  logic             clr,
`ifdef PWCHK_PROG_EN
    input  logic             prog_req,
`endif
    output logic             unlocked,
    output logic             fail,
    output logic             locked,
    output logic [3:0]       tries,
    output logic [6:0]       SSG_D,
    output logic [2:0]       SSG_EN
);

    localparam int CW = PW_LEN * BW;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int LW = $clog2(LOCK_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LOCK_CYC - 1);
    localparam logic [3:0] LAST_POS = 4'(PW_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_UNLK  = 3'd2,
        S_FAIL  = 3'd3,
        S_LOCK  = 3'd4,
        S_PROG  = 3'd5
    } state_t;

    state_t        state_q, state_d, fail_st;
    logic [3:0]    tries_q, tries_d, tries_inc;
    logic [3:0]    cnt_q, cnt_d;
    logic          match_q, match_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [CW-1:0] code;
    logic [BW-1:0] sym, code_sym;
    logic          press, valid, hit, fin, pass;

`ifdef PWCHK_PROG_EN
    logic [CW-1:0] code_q, code_d, shadow_q, shadow_d;
    assign code = code_q;
`else
    assign code = PASSWORD;
`endif

    always_comb begin
        sym = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (btn_pulse[i]) sym = BW'(i);
        end
    end

    assign press    = |btn_pulse;
    assign valid    = $onehot(btn_pulse);
    assign code_sym = code[int'(cnt_q) * BW +: BW];
    assign hit      = valid && (sym == code_sym);

    assign tries_inc = (tries_q == 4'hF) ? 4'hF : tries_q + 4'd1;
    assign fail_st   = (int'(tries_inc) >= MAX_TRIES) ? S_LOCK : S_FAIL;

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        timer_d = timer_q;
        lock_d  = lock_q;
        fin     = 1'b0;
        pass    = 1'b0;
`ifdef PWCHK_PROG_EN
        code_d   = code_q;
        shadow_d = shadow_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    match_d = match_q & hit;
                    cnt_d   = 4'd1;
                    timer_d = '0;
                    state_d = S_ENTRY;
                    if (cnt_q == LAST_POS) begin
                        fin  = 1'b1;
                        pass = match_q & hit;
                    end
                end
            end
            S_ENTRY: begin
                timer_d = timer_q + 1'b1;
                // timeout outranks a press landing in the same cycle
                if (timer_q == T_LAST) begin
                    fin = 1'b1;
                end else if (press) begin
                    match_d = match_q & hit;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == LAST_POS) begin
                        fin  = 1'b1;
                        pass = match_q & hit;
                    end
                end
            end
            S_UNLK: begin
                if (clr) begin
                    state_d = S_IDLE;
`ifdef PWCHK_PROG_EN
                end else if (prog_req) begin
                    state_d = S_PROG;
                    cnt_d   = '0;
                    timer_d = '0;
`endif
                end
            end
            S_FAIL: begin
                if (clr) state_d = S_IDLE;
            end
            S_LOCK: begin
                lock_d = lock_q + 1'b1;
                if (lock_q == L_LAST) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                    lock_d  = '0;
                end
            end
`ifdef PWCHK_PROG_EN
            S_PROG: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == T_LAST || clr) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    timer_d = '0;
                end else if (valid) begin
                    shadow_d[int'(cnt_q) * BW +: BW] = sym;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_POS) begin
                        code_d  = shadow_d;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        timer_d = '0;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin) begin
            cnt_d   = '0;
            match_d = 1'b1;
            timer_d = '0;
            lock_d  = '0;
            if (pass) begin
                state_d = S_UNLK;
                tries_d = '0;
            end else begin
                state_d = fail_st;
                tries_d = tries_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tries_q <= '0;
            cnt_q   <= '0;
            match_q <= 1'b1;
            timer_q <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            timer_q <= timer_d;
            lock_q  <= lock_d;
        end
    end

`ifdef PWCHK_PROG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= PASSWORD;
            shadow_q <= PASSWORD;
        end else begin
            code_q   <= code_d;
            shadow_q <= shadow_d;
        end
    end
`endif

    assign unlocked = (state_q == S_UNLK);
    assign fail     = (state_q == S_FAIL);
    assign locked   = (state_q == S_LOCK);
    assign tries    = tries_q;
    assign SSG_EN   = 3'b111;

    always_comb begin
        case (state_q)
            S_ENTRY: SSG_D = 7'b1111111;
            S_UNLK:  SSG_D = 7'b0010000;
            S_FAIL:  SSG_D = 7'b0000110;
            S_LOCK:  SSG_D = 7'b1000111;
            S_PROG:  SSG_D = 7'b0001100;
            default: SSG_D = 7'b1000000;
        endcase
    end

endmodule
